// File: rtl/width_gearbox_if.sv
// Handshake and status bundle for width_gearbox.
// master is the gearbox itself; slave is the producer/consumer logic attached to it.
interface width_gearbox_if #(
  parameter int IWIDTH  = 8,
  parameter int OWIDTH  = 6,
  parameter int BUFBITS = 32
);
  localparam int LW = $clog2(BUFBITS + 1);

  logic [IWIDTH-1:0] DataIn;
  logic              InValid;
  logic              InReady;
  logic [OWIDTH-1:0] DataOut;
  logic              OutValid;
  logic              OutReady;
  logic              OutLast;
  logic              Flush;
  logic [LW-1:0]     Level;
  logic              IsFull;
  logic              IsEmpty;

  modport master (
    input  DataIn, InValid, OutReady, Flush,
    output InReady, DataOut, OutValid, OutLast, Level, IsFull, IsEmpty
  );

  modport slave (
    output DataIn, InValid, OutReady, Flush,
    input  InReady, DataOut, OutValid, OutLast, Level, IsFull, IsEmpty
  );
endinterface

// File: rtl/width_gearbox.sv
// MSB-first bit-stream width converter: IWIDTH-bit words in, OWIDTH-bit words out,
// through an MSB-aligned bit buffer, with a flush that drains a zero-padded tail word.
//
// state   | meaning
// StRun   | streaming; pushes accepted while the buffer has room for a full input word
// StDrain | flush in progress; pushes held off until the buffer empties
module width_gearbox #(
  parameter int IWIDTH  = 8,
  parameter int OWIDTH  = 6,
  parameter int BUFBITS = 32
) (
  input logic             Clk,
  input logic             Reset,
  width_gearbox_if.master gb
);
  localparam int LW = $clog2(BUFBITS + 1);

  if (BUFBITS < IWIDTH + OWIDTH) begin : gBufTooSmall
    $error("width_gearbox: BUFBITS must be >= IWIDTH + OWIDTH");
  end

  typedef enum logic {StRun, StDrain} stateT;

  stateT              stateQ, stateD;
  logic [BUFBITS-1:0] bufQ, bufD;
  logic [LW-1:0]      fillQ, fillD;

  logic               flushPending;
  logic               inReady;
  logic               outValid;
  logic               push;
  logic               pop;
  logic [LW-1:0]      popBits;
  logic [LW-1:0]      fillAfterPop;
  logic [BUFBITS-1:0] shifted;
  logic [BUFBITS-1:0] inPlaced;

  assign flushPending = (stateQ == StDrain);
  assign inReady      = !flushPending && (fillQ <= LW'(BUFBITS - IWIDTH));
  assign outValid     = (fillQ >= LW'(OWIDTH)) || (flushPending && (fillQ != '0));
  assign push         = gb.InValid && inReady;
  assign pop          = outValid && gb.OutReady;

  // New input lands right below whatever survives this cycle's pop.
  always_comb begin
    popBits = '0;
    if (pop) begin
      popBits = (fillQ >= LW'(OWIDTH)) ? LW'(OWIDTH) : fillQ;
    end
    fillAfterPop = fillQ - popBits;
    shifted      = pop ? (bufQ << OWIDTH) : bufQ;
    inPlaced     = {gb.DataIn, {(BUFBITS - IWIDTH){1'b0}}} >> fillAfterPop;
    bufD         = push ? (shifted | inPlaced) : shifted;
    fillD        = fillAfterPop + (push ? LW'(IWIDTH) : '0);
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StRun:   if (gb.Flush) stateD = StDrain;
      StDrain: if (fillD == '0) stateD = StRun;
      default: stateD = StRun;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= StRun;
      bufQ   <= '0;
      fillQ  <= '0;
    end else begin
      stateQ <= stateD;
      bufQ   <= bufD;
      fillQ  <= fillD;
    end
  end

  assign gb.InReady  = inReady;
  assign gb.IsFull   = !inReady;
  assign gb.OutValid = outValid;
  assign gb.DataOut  = bufQ[BUFBITS-1 -: OWIDTH];
  assign gb.OutLast  = flushPending && (fillQ != '0) && (fillQ <= LW'(OWIDTH));
  assign gb.Level    = fillQ;
  assign gb.IsEmpty  = (fillQ == '0);
endmodule

// File: tb/tb_width_gearbox.sv
// Scoreboard bench for width_gearbox: an 8->6 unpacker with flush and a 6->8 packer,
// each checked against a bit-queue reference model.
module tb_width_gearbox;
  localparam int IW  = 8;
  localparam int OW  = 6;
  localparam int BB  = 32;
  localparam int PIW = 6;
  localparam int POW = 8;
  localparam int PBB = 32;

  logic Clk    = 1'b0;
  logic Reset  = 1'b1;
  logic PReset = 1'b1;
  always #5 Clk = ~Clk;

  width_gearbox_if #(.IWIDTH(IW), .OWIDTH(OW), .BUFBITS(BB)) gbIf ();
  width_gearbox_if #(.IWIDTH(PIW), .OWIDTH(POW), .BUFBITS(PBB)) pkIf ();

  width_gearbox #(.IWIDTH(IW), .OWIDTH(OW), .BUFBITS(BB)) dut (
    .Clk(Clk), .Reset(Reset), .gb(gbIf)
  );
  width_gearbox #(.IWIDTH(PIW), .OWIDTH(POW), .BUFBITS(PBB)) dutPack (
    .Clk(Clk), .Reset(PReset), .gb(pkIf)
  );

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- unpacker reference model (8 -> 6, flush) ----------------
  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    int            nbits;
  } expT;

  expT         expQ[$];
  bit          bitQ[$];
  int          refLevel   = 0;
  bit          refPending = 1'b0;
  logic [31:0] outLog[$];

  bit          drvPush, drvFlush, drvReset;
  logic [IW-1:0] drvData;

  task automatic commit();
    expT e;
    bit  b;
    if (drvReset) begin
      expQ.delete();
      bitQ.delete();
      refLevel   = 0;
      refPending = 1'b0;
      return;
    end
    if (drvPush) begin
      for (int i = IW - 1; i >= 0; i--) bitQ.push_back(drvData[i]);
      refLevel += IW;
    end
    while (bitQ.size() >= OW) begin
      e.data = '0;
      for (int k = 0; k < OW; k++) begin
        b = bitQ.pop_front();
        e.data = {e.data[OW-2:0], b};
      end
      e.last  = 1'b0;
      e.nbits = OW;
      expQ.push_back(e);
    end
    if (refPending) begin
      refPending = (refLevel != 0);
    end else if (drvFlush) begin
      refPending = 1'b1;
      if (bitQ.size() > 0) begin
        e.nbits = bitQ.size();
        e.data  = '0;
        for (int k = 0; k < OW; k++) begin
          b = (bitQ.size() > 0) ? bitQ.pop_front() : 1'b0;
          e.data = {e.data[OW-2:0], b};
        end
        e.last = 1'b1;
        expQ.push_back(e);
      end else if (expQ.size() > 0) begin
        e = expQ.pop_back();
        e.last = 1'b1;
        expQ.push_back(e);
      end
    end
  endtask

  task automatic step();
    drvPush  = gbIf.InValid && gbIf.InReady && !Reset;
    drvFlush = gbIf.Flush && !Reset;
    drvReset = Reset;
    drvData  = gbIf.DataIn;
    @(posedge Clk);
    #1;
    commit();
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      check("OutValid", gbIf.OutValid, (refLevel >= OW) || (refPending && refLevel != 0));
      check("InReady", gbIf.InReady, !refPending && (refLevel + IW <= BB));
      check("IsFull", gbIf.IsFull, refPending || (refLevel + IW > BB));
      check("Level", gbIf.Level, refLevel);
      check("IsEmpty", gbIf.IsEmpty, refLevel == 0);
      if (gbIf.OutValid) begin
        if (expQ.size() == 0) begin
          check("spurious OutValid", gbIf.OutValid, 1'b0);
        end else begin
          check("DataOut", gbIf.DataOut, expQ[0].data);
          check("OutLast", gbIf.OutLast, expQ[0].last);
          if (gbIf.OutReady) begin
            outLog.push_back(32'({gbIf.OutLast, gbIf.DataOut}));
            refLevel -= expQ[0].nbits;
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  // ---------------- packer reference model (6 -> 8) ----------------
  bit             pBitQ[$];
  logic [POW-1:0] pExpQ[$];
  logic [POW-1:0] pLog[$];
  int             pLevel   = 0;
  bit             packDone = 1'b0;

  task automatic pStep();
    bit             push, rst, b;
    logic [PIW-1:0] d;
    logic [POW-1:0] w;
    push = pkIf.InValid && pkIf.InReady && !PReset;
    rst  = PReset;
    d    = pkIf.DataIn;
    @(posedge Clk);
    #1;
    if (rst) begin
      pBitQ.delete();
      pExpQ.delete();
      pLevel = 0;
    end else if (push) begin
      for (int i = PIW - 1; i >= 0; i--) pBitQ.push_back(d[i]);
      pLevel += PIW;
      while (pBitQ.size() >= POW) begin
        w = '0;
        for (int k = 0; k < POW; k++) begin
          b = pBitQ.pop_front();
          w = {w[POW-2:0], b};
        end
        pExpQ.push_back(w);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!PReset) begin
      check("pack Level", pkIf.Level, pLevel);
      check("pack OutValid", pkIf.OutValid, pLevel >= POW);
      if (pkIf.OutValid && pExpQ.size() > 0) begin
        check("pack DataOut", pkIf.DataOut, pExpQ[0]);
        if (pkIf.OutReady) begin
          pLog.push_back(pkIf.DataOut);
          pLevel -= POW;
          void'(pExpQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic [PIW-1:0] pkVec [4];
    pkVec[0] = 6'h29; pkVec[1] = 6'h13; pkVec[2] = 6'h33; pkVec[3] = 6'h30;
    pkIf.DataIn = '0; pkIf.InValid = 1'b0; pkIf.OutReady = 1'b1; pkIf.Flush = 1'b0;
    PReset = 1'b1;
    pStep(); pStep();
    PReset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pkIf.InValid = 1'b1;
      pkIf.DataIn  = pkVec[i];
      pStep();
    end
    pkIf.InValid = 1'b0;
    repeat (3) pStep();
    check("pack word count", pLog.size(), 3);
    if (pLog.size() == 3) begin
      check("pack word0", pLog[0], 8'hA5);
      check("pack word1", pLog[1], 8'h3C);
      check("pack word2", pLog[2], 8'hF0);
    end
    check("pack Level idle", pkIf.Level, 0);
    for (int i = 0; i < 800; i++) begin
      pkIf.InValid  = ($urandom_range(0, 99) < 75);
      pkIf.DataIn   = PIW'($urandom);
      pkIf.OutReady = ($urandom_range(0, 99) < 60);
      pStep();
    end
    pkIf.InValid  = 1'b0;
    pkIf.OutReady = 1'b1;
    repeat (10) pStep();
    check("pack leftover words", pExpQ.size(), 0);
    check("pack leftover bits", pkIf.Level, pBitQ.size());
    packDone = 1'b1;
  end

  // ---------------- unpacker stimulus ----------------
  initial begin
    logic [IW-1:0] uVec [3];
    int            accepted;
    int            budget;
    uVec[0] = 8'hA5; uVec[1] = 8'h3C; uVec[2] = 8'hF0;
    gbIf.DataIn = '0; gbIf.InValid = 1'b0; gbIf.OutReady = 1'b0; gbIf.Flush = 1'b0;
    Reset = 1'b1;
    step(); step();
    check("reset InReady", gbIf.InReady, 1'b1);
    check("reset OutValid", gbIf.OutValid, 1'b0);
    check("reset DataOut", gbIf.DataOut, 0);
    check("reset IsEmpty", gbIf.IsEmpty, 1'b1);
    Reset = 1'b0;

    // back-to-back unpack
    gbIf.OutReady = 1'b1;
    outLog.delete();
    for (int i = 0; i < 3; i++) begin
      gbIf.InValid = 1'b1;
      gbIf.DataIn  = uVec[i];
      step();
    end
    gbIf.InValid = 1'b0;
    repeat (4) step();
    check("unpack count", outLog.size(), 4);
    if (outLog.size() == 4) begin
      check("unpack w0", outLog[0], 32'h29);
      check("unpack w1", outLog[1], 32'h13);
      check("unpack w2", outLog[2], 32'h33);
      check("unpack w3", outLog[3], 32'h30);
    end
    check("unpack Level", gbIf.Level, 0);
    check("unpack IsEmpty", gbIf.IsEmpty, 1'b1);

    // push then flush
    outLog.delete();
    gbIf.InValid = 1'b1; gbIf.DataIn = 8'hA5;
    step();
    gbIf.InValid = 1'b0; gbIf.Flush = 1'b1;
    step();
    gbIf.Flush = 1'b0;
    repeat (3) step();
    check("flush count", outLog.size(), 2);
    if (outLog.size() == 2) begin
      check("flush w0", outLog[0], 32'h29);
      check("flush w1 last", outLog[1], 32'h50);
    end
    check("flush InReady back", gbIf.InReady, 1'b1);

    // flush while empty
    gbIf.Flush = 1'b1;
    step();
    gbIf.Flush = 1'b0;
    check("empty flush OutValid", gbIf.OutValid, 1'b0);
    check("empty flush InReady", gbIf.InReady, 1'b0);
    step();
    check("empty flush cleared", gbIf.InReady, 1'b1);

    // flush coincident with push
    outLog.delete();
    gbIf.InValid = 1'b1; gbIf.DataIn = 8'hA5; gbIf.Flush = 1'b1;
    step();
    gbIf.InValid = 1'b0; gbIf.Flush = 1'b0;
    repeat (3) step();
    check("coinc count", outLog.size(), 2);
    if (outLog.size() == 2) begin
      check("coinc w0", outLog[0], 32'h29);
      check("coinc w1 last", outLog[1], 32'h50);
    end

    // backpressure
    gbIf.OutReady = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      gbIf.InValid = 1'b1;
      gbIf.DataIn  = (i == 0) ? 8'hA5 : IW'($urandom);
      if (gbIf.InReady) accepted++;
      step();
    end
    gbIf.InValid = 1'b0;
    check("bp accepted", accepted, 4);
    check("bp Level", gbIf.Level, 32);
    check("bp InReady", gbIf.InReady, 1'b0);
    check("bp DataOut held", gbIf.DataOut, 6'h29);
    gbIf.OutReady = 1'b1;
    repeat (6) step();
    check("bp tail Level", gbIf.Level, 2);
    gbIf.Flush = 1'b1;
    step();
    gbIf.Flush = 1'b0;
    repeat (3) step();
    check("bp drained", gbIf.Level, 0);

    // reset with data buffered and a flush pending
    gbIf.OutReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gbIf.InValid = 1'b1;
      gbIf.DataIn  = IW'($urandom);
      step();
    end
    gbIf.InValid = 1'b0; gbIf.Flush = 1'b1;
    step();
    gbIf.Flush = 1'b0; gbIf.OutReady = 1'b1;
    step(); step();
    gbIf.OutReady = 1'b0;
    check("pre-reset Level", gbIf.Level, 20);
    check("pre-reset InReady", gbIf.InReady, 1'b0);
    Reset = 1'b1;
    gbIf.InValid = 1'b1; gbIf.DataIn = 8'hFF; gbIf.Flush = 1'b1; gbIf.OutReady = 1'b1;
    step();
    Reset = 1'b0;
    gbIf.InValid = 1'b0; gbIf.Flush = 1'b0; gbIf.OutReady = 1'b0;
    check("rst Level", gbIf.Level, 0);
    check("rst OutValid", gbIf.OutValid, 1'b0);
    check("rst InReady", gbIf.InReady, 1'b1);
    check("rst DataOut", gbIf.DataOut, 0);
    check("rst OutLast", gbIf.OutLast, 1'b0);
    check("rst IsFull", gbIf.IsFull, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      gbIf.InValid  = ($urandom_range(0, 99) < 70);
      gbIf.DataIn   = IW'($urandom);
      gbIf.OutReady = ($urandom_range(0, 99) < 70);
      gbIf.Flush    = ($urandom_range(0, 99) < 3);
      step();
    end
    gbIf.InValid = 1'b0; gbIf.OutReady = 1'b1; gbIf.Flush = 1'b1;
    step();
    gbIf.Flush = 1'b0;
    budget = 0;
    while ((refLevel != 0 || refPending || expQ.size() != 0) && budget < 60) begin
      step();
      budget++;
    end
    check("random drain in budget", budget < 60, 1'b1);
    check("random leftover words", expQ.size(), 0);

    budget = 0;
    while (!packDone && budget < 20000) begin
      @(posedge Clk);
      budget++;
    end
    check("pack bench completed", packDone, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
